// File: rtl/spi_ctrl_pkg.sv
// Shared types and defaults for the SPI burst sequencer: FSM state encoding,
// default chip-select timing and the sizing rule for the shared delay counter.
package spi_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_LOAD,
    ST_ISSUE,
    ST_WAIT,
    ST_GAP,
    ST_HOLD,
    ST_DONE
  } state_e;

  localparam int unsigned CS_SETUP_DEF = 2;
  localparam int unsigned CS_HOLD_DEF  = 2;
  localparam int unsigned BYTE_GAP_DEF = 1;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // One spare bit so the largest programmed delay always fits.
  function automatic int unsigned dly_width(input int unsigned s, input int unsigned h,
                                            input int unsigned g);
    return $clog2(max3(s, h, g)) + 1;
  endfunction

endpackage

// File: rtl/spi_burst_ctrl_if.sv
// Bundle of command, transmit, receive, chip-select and byte-engine signals.
// master = the sequencer itself; slave = the bus bridge and byte engine around it.
interface spi_burst_ctrl_if;

  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_len;
  logic       cmd_keep_cs;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       abort;
  logic       cs_n;
  logic       busy;
  logic       done;
  logic       eng_start;
  logic [7:0] eng_data_in;
  logic [7:0] eng_data_out;
  logic       eng_busy;

  modport master (
    input  cmd_valid, cmd_len, cmd_keep_cs, tx_valid, tx_data, abort,
           eng_data_out, eng_busy,
    output cmd_ready, tx_ready, rx_valid, rx_data, cs_n, busy, done,
           eng_start, eng_data_in
  );

  modport slave (
    output cmd_valid, cmd_len, cmd_keep_cs, tx_valid, tx_data, abort,
           eng_data_out, eng_busy,
    input  cmd_ready, tx_ready, rx_valid, rx_data, cs_n, busy, done,
           eng_start, eng_data_in
  );

endinterface

// File: rtl/spi_ctrl_delay.sv
// Loadable down-counter shared by the SETUP, GAP and HOLD phases.
// Loading N gives N+1 cycles until zero is seen (the load cycle is the first).
module spi_ctrl_delay #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_value;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/spi_burst_ctrl.sv
// SPI transaction sequencer: frames N-byte commands with chip-select setup,
// hold and inter-byte gaps, and is the sole driver of the byte engine's start.
module spi_burst_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter int unsigned CS_SETUP = CS_SETUP_DEF,
  parameter int unsigned CS_HOLD  = CS_HOLD_DEF,
  parameter int unsigned BYTE_GAP = BYTE_GAP_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  spi_burst_ctrl_if.master bus
);

  localparam int unsigned DW = dly_width(CS_SETUP, CS_HOLD, BYTE_GAP);
  localparam logic [DW-1:0] SETUP_LD = DW'(CS_SETUP - 1);
  localparam logic [DW-1:0] HOLD_LD  = (CS_HOLD > 0)  ? DW'(CS_HOLD - 1)  : '0;
  localparam logic [DW-1:0] GAP_LD   = (BYTE_GAP > 0) ? DW'(BYTE_GAP - 1) : '0;

  state_e     r_state;
  logic [7:0] r_remaining;
  logic       r_keep;
  logic       r_abort;
  logic       r_seen_busy;
  logic       r_cs_n;
  logic       r_busy;
  logic       r_done;
  logic       r_cmd_ready;
  logic       r_rx_valid;
  logic [7:0] r_rx_data;
  logic       r_eng_start;
  logic [7:0] r_eng_data_in;

  logic          w_accept;
  logic          w_complete;
  logic          w_stop;
  logic          w_release;
  logic          w_dly_load;
  logic [DW-1:0] w_dly_value;
  logic          w_dly_zero;
  state_e        w_exit_state;
  logic          w_exit_rise;

  assign w_accept   = (r_state == ST_IDLE) && r_cmd_ready && bus.cmd_valid;
  // eng_busy is only trusted once it has been seen high for this byte.
  assign w_complete = (r_state == ST_WAIT) && r_seen_busy && !bus.eng_busy;
  assign w_stop     = (r_remaining == 8'd1) || r_abort || bus.abort;
  assign w_release  = !r_keep || r_abort || bus.abort;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    w_dly_load   = 1'b0;
    w_dly_value  = HOLD_LD;
    w_exit_state = ST_DONE;
    w_exit_rise  = 1'b0;
    if (w_accept) begin
      w_dly_load  = 1'b1;
      w_dly_value = SETUP_LD;
    end else if (w_complete) begin
      w_dly_load  = 1'b1;
      w_dly_value = w_stop ? HOLD_LD : GAP_LD;
    end else if ((r_state == ST_LOAD) && r_abort) begin
      w_dly_load  = 1'b1;
    end
    if (w_release) begin
      if (CS_HOLD == 0) w_exit_rise  = 1'b1;
      else              w_exit_state = ST_HOLD;
    end
  end

  spi_ctrl_delay #(.W(DW)) u_delay (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_dly_load),
    .i_value (w_dly_value),
    .o_zero  (w_dly_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_remaining   <= '0;
      r_keep        <= 1'b0;
      r_abort       <= 1'b0;
      r_seen_busy   <= 1'b0;
      r_cs_n        <= 1'b1;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_cmd_ready   <= 1'b0;
      r_rx_valid    <= 1'b0;
      r_rx_data     <= '0;
      r_eng_start   <= 1'b0;
      r_eng_data_in <= '0;
    end else begin
      r_done      <= 1'b0;
      r_rx_valid  <= 1'b0;
      r_eng_start <= 1'b0;
      if (r_state != ST_IDLE) r_abort <= r_abort | bus.abort;

      case (r_state)
        ST_IDLE: begin
          r_cmd_ready <= 1'b1;
          if (w_accept) begin
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_remaining <= bus.cmd_len;
            r_keep      <= bus.cmd_keep_cs;
            if (bus.cmd_len == 8'd0) begin
              r_state <= ST_DONE;
            end else if (!r_cs_n) begin
              r_state <= ST_LOAD;
            end else begin
              r_cs_n  <= 1'b0;
              r_state <= ST_SETUP;
            end
          end
        end
        ST_SETUP: if (w_dly_zero) r_state <= ST_LOAD;
        ST_LOAD: begin
          if (r_abort) begin
            r_state <= w_exit_state;
            if (w_exit_rise) r_cs_n <= 1'b1;
          end else if (bus.tx_valid) begin
            r_eng_data_in <= bus.tx_data;
            r_eng_start   <= 1'b1;
            r_state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_seen_busy <= 1'b0;
          r_state     <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.eng_busy) r_seen_busy <= 1'b1;
          if (w_complete) begin
            r_rx_data   <= bus.eng_data_out;
            r_rx_valid  <= 1'b1;
            r_remaining <= r_remaining - 8'd1;
            if (w_stop) begin
              r_state <= w_exit_state;
              if (w_exit_rise) r_cs_n <= 1'b1;
            end else begin
              r_state <= (BYTE_GAP == 0) ? ST_LOAD : ST_GAP;
            end
          end
        end
        ST_GAP: if (w_dly_zero) r_state <= ST_LOAD;
        ST_HOLD: begin
          if (w_dly_zero) begin
            r_cs_n  <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b1;
          r_abort <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready   = r_cmd_ready;
  assign bus.tx_ready    = (r_state == ST_LOAD) && !r_abort && bus.tx_valid;
  assign bus.rx_valid    = r_rx_valid;
  assign bus.rx_data     = r_rx_data;
  assign bus.cs_n        = r_cs_n;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.eng_start   = r_eng_start;
  assign bus.eng_data_in = r_eng_data_in;

endmodule

// File: doc/spi_burst_ctrl.md
# spi_burst_ctrl

Transaction sequencer in front of the SPI byte engine. It accepts a command of N bytes and drives chip-select with programmable setup, hold and inter-byte gap times. It feeds transmit bytes to the engine one at a time and returns each received byte as a one-cycle pulse. It sits between the register/bus bridge and the byte engine; it is the only master of the engine's `start` input.

## Interface
- `CS_SETUP`, default 2: cycles from `cs_n` falling to the first `eng_start`; minimum 1.
- `CS_HOLD`, default 2: cycles from the last byte's completion to `cs_n` rising; 0 is legal.
- `BYTE_GAP`, default 1: idle cycles between a byte's completion and the next `eng_start`; 0 is legal.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cmd_valid` / `cmd_ready`  in/out  1  command handshake; transfer when both are high.
- `cmd_len`  in  8  number of bytes, 0..255.
- `cmd_keep_cs`  in  1  leave `cs_n` low after the last byte (chained commands).
- `tx_valid` / `tx_ready`  in/out  1  transmit byte handshake.
- `tx_data`  in  8  byte to send.
- `rx_valid`  out  1  one-cycle pulse: `rx_data` valid; no backpressure.
- `rx_data`  out  8  received byte; held until the next `rx_valid`.
- `abort`  in  1  stop after the byte in flight.
- `cs_n`  out  1  chip select, active low.
- `busy`  out  1  state is not IDLE.
- `done`  out  1  one-cycle pulse at the end of a command.
- `eng_start`  out  1  one-cycle pulse to the engine.
- `eng_data_in`  out  8  byte to the engine.
- `eng_data_out`  in  8  engine result.
- `eng_busy`  in  1  engine busy.

## Operation
- States: IDLE, SETUP, LOAD, ISSUE, WAIT, GAP, HOLD, DONE.
- **IDLE**
  - `cmd_ready` = 1.
  - On accept: latch `remaining` = `cmd_len` and `keep` = `cmd_keep_cs`.
  - `cmd_len` = 0 → DONE; `cs_n` is untouched.
  - Otherwise, if `cs_n` is already low (previous keep) → LOAD; else drive `cs_n` = 0 and go to SETUP.
- **SETUP**: count `CS_SETUP` cycles → LOAD.
- **LOAD**
  - `tx_ready` = `tx_valid` (combinational).
  - On transfer: register `eng_data_in` = `tx_data` → ISSUE.
  - Stall indefinitely with `cs_n` held if `tx_valid` is low.
- **ISSUE**: `eng_start` = 1 for exactly this cycle; clear `seen_busy` → WAIT.
- **WAIT**
  - Set `seen_busy` when `eng_busy` = 1.
  - Completion = `seen_busy` and `eng_busy` = 0.
  - On completion: register `rx_data` = `eng_data_out`, pulse `rx_valid` next cycle, decrement `remaining`.
  - `eng_busy` low in the ISSUE+1 cycle is not completion.
- **After completion**:
  - `remaining` = 0, or `abort` latched → HOLD if `keep` = 0, else DONE with `cs_n` held low.
  - Otherwise → GAP, or directly to LOAD when `BYTE_GAP` = 0.
- **GAP**: count `BYTE_GAP` cycles → LOAD.
- **HOLD**: count `CS_HOLD` cycles, then `cs_n` = 1 → DONE. With `CS_HOLD` = 0, `cs_n` rises at the DONE entry.
- **DONE**: `done` = 1 for one cycle → IDLE.
- **abort**
  - Sampled in any non-IDLE state into a sticky flag; the flag clears in DONE.
  - In LOAD with no byte taken: go to the completion exit immediately.
  - An aborted command forces `cs_n` high regardless of `keep`.
- **Widths**: `remaining` is 8-bit; the delay counter width is clog2 of the largest parameter + 1.

## Timing
- Reset values: `cs_n` = 1; `cmd_ready` = 0 during reset and 1 from the first cycle after release. All other outputs 0: `busy`, `done`, `rx_valid`, `tx_ready`, `eng_start`, `rx_data`, `eng_data_in`. State = IDLE.
- Reset asserted mid-transfer: `cs_n` goes high asynchronously; the engine is not notified.
- Accept at cycle T, fresh CS: `cs_n` low at T+1; earliest `eng_start` at T+1+`CS_SETUP`+1 (one LOAD cycle).
- `rx_valid` comes 1 cycle after the completion cycle.
- Per-byte overhead beyond engine time: LOAD + ISSUE + completion + `BYTE_GAP` = 3 + `BYTE_GAP` cycles.
- `done` is one cycle after `cs_n` rises, or one cycle after the last `rx_valid` with keep.
- A new command cannot be accepted in the same cycle as `done`.

## Structure
- Package `spi_ctrl_pkg`: state enum/localparams and the default `CS_SETUP` / `CS_HOLD` / `BYTE_GAP` values.
- One sub-module `spi_ctrl_delay`: loadable down-counter with `load`, `value`, and a `zero` flag. It is shared by SETUP, GAP and HOLD and instantiated once.
- Engine handshake logic lives inline in the FSM.

## Test plan
- **Single byte**: `cmd_len` = 1, tx = 0xA5, engine model returns 0x3C.
  - `cs_n` low for SETUP+byte+HOLD.
  - One `eng_start`; `rx_data` = 0x3C; one `done`; `cs_n` = 1 afterwards.
- **Burst of 4**: tx 0x01..0x04, model echoes bitwise inverse.
  - 4 `rx_valid` pulses: 0xFE, 0xFD, 0xFC, 0xFB.
  - `eng_start` spacing = engine time + 3 + `BYTE_GAP` cycles; `cs_n` never toggles mid-burst.
- **tx underflow**: `tx_valid` dropped for 10 cycles before byte 2 → `cs_n` stays low, no `eng_start`, transfer resumes correctly.
- **Chained commands**: `cmd_keep_cs` = 1 with `cmd_len` = 2, then a second command with `cmd_len` = 1 and keep = 0.
  - No `cs_n` high between commands; second command skips SETUP; `cs_n` rises only after the third byte.
- **Zero length and abort**:
  - `cmd_len` = 0 → `done` 2 cycles after accept, `cs_n` stays 1.
  - `cmd_len` = 5 with `abort` pulsed during byte 2 → exactly 2 `rx_valid`, then HOLD, `cs_n` = 1, `done`.
- **Async reset mid-byte**: `rst_n` low during WAIT → `cs_n` = 1 within the same cycle and all outputs at reset values; the next command behaves normally.
